// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first pattern transmitter with repeat, inter-frame gap and stall
module seq_pattern_gen #(
   parameter int PATTERN_W = 8,
   parameter int LEN_W     = $clog2(PATTERN_W) + 1,
   parameter int REP_W     = 4,
   parameter int GAP_W     = 4
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic [PATTERN_W-1:0] pattern_i,
   input  logic [LEN_W-1:0]     len_i,
   input  logic [REP_W-1:0]     repeat_i,
   input  logic [GAP_W-1:0]     gap_i,
   input  logic                 stall_i,
   output logic                 out_o,
   output logic                 out_valid_o,
   output logic                 frame_o,
   output logic                 busy_o,
   output logic                 done_o
);
   localparam int IW = $clog2(PATTERN_W);
   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
   state_t               state;
   logic [PATTERN_W-1:0] pat;
   logic [IW-1:0]        top, idx, top_in;
   logic [REP_W-1:0]     frames;
   logic [GAP_W-1:0]     gap, gap_cnt;
   logic [LEN_W-1:0]     eff_len;
   always_comb begin
      eff_len = (len_i == '0 || len_i > LEN_W'(PATTERN_W)) ? LEN_W'(PATTERN_W) : len_i;
      top_in  = IW'(eff_len - 1'b1);
   end
   // outputs are registered: each edge loads what the next cycle must show
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state       <= IDLE;
         pat         <= '0;
         top         <= '0;
         idx         <= '0;
         frames      <= '0;
         gap         <= '0;
         gap_cnt     <= '0;
         out_o       <= 1'b0;
         out_valid_o <= 1'b0;
         frame_o     <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         out_valid_o <= 1'b0;
         frame_o     <= 1'b0;
         done_o      <= 1'b0;
         case (state)
            IDLE: begin
               out_o  <= 1'b0;
               busy_o <= 1'b0;
               if (start_i) begin
                  state       <= SEND;
                  pat         <= pattern_i;
                  top         <= top_in;
                  idx         <= top_in;
                  frames      <= repeat_i;
                  gap         <= gap_i;
                  out_o       <= pattern_i[top_in];
                  out_valid_o <= 1'b1;
                  frame_o     <= 1'b1;
                  busy_o      <= 1'b1;
               end
            end
            SEND: if (!stall_i) begin
               if (idx != '0) begin
                  idx         <= idx - 1'b1;
                  out_o       <= pat[idx - 1'b1];
                  out_valid_o <= 1'b1;
               end else if (frames == '0) begin
                  state  <= DONE;
                  out_o  <= 1'b0;
                  done_o <= 1'b1;
               end else begin
                  frames <= frames - 1'b1;
                  if (gap == '0) begin
                     idx         <= top;
                     out_o       <= pat[top];
                     out_valid_o <= 1'b1;
                     frame_o     <= 1'b1;
                  end else begin
                     state   <= GAP;
                     gap_cnt <= gap - 1'b1;
                     out_o   <= 1'b0;
                  end
               end
            end
            GAP: if (!stall_i) begin
               if (gap_cnt == '0) begin
                  state       <= SEND;
                  idx         <= top;
                  out_o       <= pat[top];
                  out_valid_o <= 1'b1;
                  frame_o     <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               out_o  <= 1'b0;
               busy_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: scoreboard bench for seq_pattern_gen
module tb_seq_pattern_gen;
   logic       clk = 1'b0;
   logic       rst, start, stall;
   logic [7:0] pattern;
   logic [3:0] len, rep, gap;
   logic       out, out_valid, frame, busy, done;
   int         n_cmp = 0, n_err = 0;
   typedef struct packed {logic b; logic f;} exp_t;
   exp_t q[$];
   seq_pattern_gen dut (
      .clock_i(clk), .reset_i(rst), .start_i(start), .pattern_i(pattern),
      .len_i(len), .repeat_i(rep), .gap_i(gap), .stall_i(stall),
      .out_o(out), .out_valid_o(out_valid), .frame_o(frame), .busy_o(busy), .done_o(done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic idle_chk(input string tag);
      chk({tag, "_out"}, out, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_frame"}, frame, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask
   // called at a negedge with the DUT idle; start is sampled at the next edge
   task automatic run(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                      input logic [3:0] g, input int st_at, input int st_n, input int mid);
      int   eff, frames, done_cyc, n_done, n_frame, busy_low;
      bit   fin;
      exp_t e;
      eff = (l == 0 || l > 8) ? 8 : int'(l);
      frames = int'(r) + 1;
      for (int f = 0; f < frames; f++)
         for (int i = eff - 1; i >= 0; i--) begin
            e.b = p[i];
            e.f = (i == eff - 1);
            q.push_back(e);
         end
      pattern = p; len = l; rep = r; gap = g; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n_done = 0; n_frame = 0; done_cyc = 0; busy_low = 0; fin = 0;
      for (int c = 1; c <= 200 && !fin; c++) begin
         @(negedge clk);
         if (out_valid) begin
            if (q.size() == 0) chk("extra_bit", 1, 0);
            else begin
               e = q.pop_front();
               chk("bit", out, e.b);
               chk("frame", frame, e.f);
            end
            n_frame += int'(frame);
         end else begin
            chk("frame_idle", frame, 0);
            if (st_n == 0) chk("out_idle", out, 0);
         end
         if (done) begin
            n_done++;
            done_cyc = c;
            chk("done_valid", out_valid, 0);
            chk("done_busy", busy, 1);
         end
         if (!busy) begin
            busy_low = c;
            fin = 1;
         end
         stall = (c >= st_at && c < st_at + st_n);
         if (c == mid) begin
            start = 1'b1; pattern = ~p; len = 3; rep = 2; gap = 1;
         end else start = 1'b0;
      end
      stall = 1'b0;
      start = 1'b0;
      chk("finished", int'(fin), 1);
      chk("done_count", n_done, 1);
      chk("done_cycle", done_cyc, frames * eff + (frames - 1) * int'(g) + 1 + st_n);
      chk("idle_cycle", busy_low, done_cyc + 1);
      chk("frames", n_frame, frames);
      chk("leftover", q.size(), 0);
      q.delete();
   endtask
   initial begin
      rst = 1'b1; start = 1'b0; stall = 1'b0; pattern = '0; len = '0; rep = '0; gap = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      idle_chk("reset");
      rst = 1'b0;
      @(negedge clk);
      run(8'h0B, 4, 0, 0, 0, 0, 0);
      run(8'h06, 3, 2, 2, 0, 0, 0);
      run(8'hA5, 0, 1, 0, 0, 0, 0);
      run(8'h0B, 4, 0, 0, 2, 3, 0);
      run(8'h0B, 4, 0, 0, 0, 0, 2);
      run(8'h02, 2, 15, 0, 0, 0, 0);
      run(8'h5A, 12, 0, 1, 0, 0, 0);
      run(8'h01, 1, 2, 1, 0, 0, 0);
      run(8'h06, 3, 2, 2, 5, 2, 0);
      pattern = 8'h0B; len = 4; rep = 3; gap = 0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      idle_chk("midrst");
      rst = 1'b0;
      @(negedge clk);
      idle_chk("postrst");
      run(8'h0B, 4, 0, 0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
